// File: rtl/updown_counter_bank.sv
// Bank of independent up/down counters, each stepped by active-low inc/dec keys.
// The key filter is built only when UPDOWN_COUNTER_DEBOUNCE_EN is defined.
module updown_counter_bank #(
    parameter int CHANNELS        = 2,
    parameter int WIDTH           = 10,
    parameter int SATURATE        = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       inc_n,
    input  logic [CHANNELS-1:0]       dec_n,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       at_max,
    output logic [CHANNELS-1:0]       at_min,
    output logic [CHANNELS-1:0]       wrap
);

    localparam int KEYS = 2 * CHANNELS;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    if (CHANNELS < 1 || CHANNELS > 8 || WIDTH < 2 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("updown_counter_bank: parameter out of range");
    end

    // Key index k < CHANNELS is an inc key, the upper half are dec keys.
    logic [KEYS-1:0] key_n_s;
    logic [KEYS-1:0] sync1_d, sync1_q;
    logic [KEYS-1:0] sync2_d, sync2_q;
    logic [KEYS-1:0] acc_d, acc_q;
    logic [KEYS-1:0] acc_prev_d, acc_prev_q;
    logic [KEYS-1:0] press_s;

    assign key_n_s = {dec_n, inc_n};

    // Next state of the synchroniser chain and the accepted-level history.
    always_comb begin
        sync1_d    = key_n_s;
        sync2_d    = sync1_q;
        acc_prev_d = acc_q;
    end

    // Synchroniser flops, accepted levels and their one-cycle history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            acc_q      <= '1;
            acc_prev_q <= '1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            acc_q      <= acc_d;
            acc_prev_q <= acc_prev_d;
        end
    end

`ifdef UPDOWN_COUNTER_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] STAB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] stab_d [KEYS];
    logic [DBW-1:0] stab_q [KEYS];

    // A new level is adopted on the DEBOUNCE_CYCLES-th consecutive differing clock.
    always_comb begin
        acc_d  = acc_q;
        stab_d = stab_q;
        for (int k = 0; k < KEYS; k++) begin
            if (sync2_q[k] != acc_q[k]) begin
                if (stab_q[k] == STAB_LAST) begin
                    acc_d[k]  = sync2_q[k];
                    stab_d[k] = '0;
                end else begin
                    stab_d[k] = stab_q[k] + DBW'(1);
                end
            end else begin
                stab_d[k] = '0;
            end
        end
    end

    // Stability counters, one per key.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stab_q <= '{default: '0};
        end else begin
            stab_q <= stab_d;
        end
    end
`else
    // Without the filter the accepted level is the synchronised key, registered once.
    always_comb begin
        acc_d = sync2_q;
    end
`endif

    // Press is the cycle after the accepted level falls; releases are ignored.
    assign press_s = acc_prev_q & ~acc_q;

    logic [CHANNELS-1:0] inc_evt_s, dec_evt_s;
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [CHANNELS-1:0] wrap_d, wrap_q;

    assign inc_evt_s = press_s[CHANNELS-1:0];
    assign dec_evt_s = press_s[KEYS-1:CHANNELS];

    // Per-channel count update: clear wins, opposing presses cancel.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (clear) begin
                cnt_d[c] = '0;
            end else if (inc_evt_s[c] && !dec_evt_s[c]) begin
                if (cnt_q[c] != CNT_MAX) begin
                    cnt_d[c] = cnt_q[c] + WIDTH'(1);
                end else if (SATURATE == 0) begin
                    cnt_d[c]  = '0;
                    wrap_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c];
                end
            end else if (dec_evt_s[c] && !inc_evt_s[c]) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    cnt_d[c]  = CNT_MAX;
                    wrap_d[c] = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c];
                end
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '{default: '0};
            wrap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_out
        assign count[c*WIDTH +: WIDTH] = cnt_q[c];
        assign at_max[c]               = (cnt_q[c] == CNT_MAX);
        assign at_min[c]               = (cnt_q[c] == '0);
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_updown_counter_bank.sv
// Scoreboard bench for updown_counter_bank (CHANNELS=2, WIDTH=4, DEBOUNCE_CYCLES=4),
// with a second SATURATE=1 instance for clamping behaviour.
module tb_updown_counter_bank;

    localparam int CH = 2;
    localparam int W  = 4;
    localparam int DB = 4;
`ifdef UPDOWN_COUNTER_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 4;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [CH-1:0]   inc_n, dec_n, s_inc_n, s_dec_n;
    logic            clear, s_clear;
    logic [CH*W-1:0] count, s_count;
    logic [CH-1:0]   at_max, at_min, wrap, s_at_max, s_at_min, s_wrap;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    updown_counter_bank #(.CHANNELS(CH), .WIDTH(W), .SATURATE(0), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .inc_n(inc_n), .dec_n(dec_n), .clear(clear),
        .count(count), .at_max(at_max), .at_min(at_min), .wrap(wrap)
    );

    updown_counter_bank #(.CHANNELS(CH), .WIDTH(W), .SATURATE(1), .DEBOUNCE_CYCLES(DB)) dut_sat (
        .clk(clk), .reset_n(reset_n), .inc_n(s_inc_n), .dec_n(s_dec_n), .clear(s_clear),
        .count(s_count), .at_max(s_at_max), .at_min(s_at_min), .wrap(s_wrap)
    );

    typedef struct {
        int         ch;
        logic [W-1:0] val;
        logic       wr;
        int         due;
    } sb_t;

    sb_t          sb_q[$];
    logic [W-1:0] mdl [CH];
    logic [W-1:0] last_cnt [CH];
    bit           mon_en = 1'b0;
    bit           sat_wrap_seen, sat_min_dropped;
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_step(input int c, input bit up);
        sb_t e;
        logic [W-1:0] nv;
        bit wr;
        if (up) begin
            nv = mdl[c] + 4'd1;
            wr = (mdl[c] == 4'hF);
        end else begin
            nv = mdl[c] - 4'd1;
            wr = (mdl[c] == 4'h0);
        end
        e.ch = c; e.val = nv; e.wr = wr; e.due = cyc + LAT;
        sb_q.push_back(e);
        mdl[c] = nv;
    endtask

    task automatic check_state(input string tag);
        for (int c = 0; c < CH; c++) begin
            check_eq($sformatf("%s_cnt%0d", tag, c), count[c*W +: W], mdl[c]);
            check_eq($sformatf("%s_min%0d", tag, c), at_min[c], mdl[c] == 4'h0);
            check_eq($sformatf("%s_max%0d", tag, c), at_max[c], mdl[c] == 4'hF);
        end
    endtask

    task automatic press(input logic [CH-1:0] im, input logic [CH-1:0] dm, input int hold);
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            if (im[c] ^ dm[c]) push_step(c, im[c]);
        end
        inc_n = ~im;
        dec_n = ~dm;
        tick(hold);
        inc_n = '1;
        dec_n = '1;
        tick(2 * LAT);
    endtask

    // Output monitor: every count change must match the next expected entry for its channel.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                logic [W-1:0] cur;
                int idx;
                cur = count[c*W +: W];
                if (mon_en) begin
                    idx = -1;
                    for (int i = 0; i < sb_q.size(); i++) begin
                        if (idx < 0 && sb_q[i].ch == c) idx = i;
                    end
                    if (cur != last_cnt[c]) begin
                        if (idx < 0) begin
                            check_eq($sformatf("spurious_ch%0d", c), cur, last_cnt[c]);
                        end else begin
                            check_eq($sformatf("val_ch%0d", c), cur, sb_q[idx].val);
                            check_eq($sformatf("wrap_ch%0d", c), wrap[c], sb_q[idx].wr);
                            check_eq($sformatf("when_ch%0d", c), cyc, sb_q[idx].due);
                            sb_q.delete(idx);
                        end
                    end else begin
                        check_eq($sformatf("wrap_idle_ch%0d", c), wrap[c], 1'b0);
                        if (idx >= 0 && cyc > sb_q[idx].due) begin
                            check_eq($sformatf("late_ch%0d", c), cyc, sb_q[idx].due);
                            sb_q.delete(idx);
                        end
                    end
                end
                last_cnt[c] = cur;
            end
        end
    end

    // Sticky observers for the saturating instance, channel 1.
    initial begin
        forever begin
            @(negedge clk);
            if (s_wrap != 2'b00) sat_wrap_seen = 1'b1;
            if (!s_at_min[1]) sat_min_dropped = 1'b1;
        end
    end

    initial begin
        logic [7:0] pat;
        reset_n = 1'b1; inc_n = '1; dec_n = '1; clear = 1'b0;
        s_inc_n = '1; s_dec_n = '1; s_clear = 1'b0;
        for (int c = 0; c < CH; c++) mdl[c] = '0;
        #1 reset_n = 1'b0;
        tick(3);
        check_eq("rst_count", count, 8'h00);
        check_eq("rst_at_min", at_min, 2'b11);
        check_eq("rst_at_max", at_max, 2'b00);
        check_eq("rst_wrap", wrap, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        #1 mon_en = 1'b1;

        // Held press gives exactly one increment on channel 0 only.
        press(2'b01, 2'b00, 10);
        check_state("hold");

        // Glitchy press: 0,0,0,1,0,0,0,0 one value per clock.
        pat = 8'b0000_1000;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            inc_n[0] = pat[i];
`ifdef UPDOWN_COUNTER_DEBOUNCE_EN
            if (i == 4) push_step(0, 1'b1);
`else
            if (i == 0 || i == 4) push_step(0, 1'b1);
`endif
            @(negedge clk);
        end
        inc_n[0] = 1'b1;
        tick(2 * LAT);
        check_state("glitch");

        // Channel 1 decrements through zero, channel 0 climbs to max.
        press(2'b00, 2'b10, LAT + 1);
        while (mdl[0] != 4'hF) press(2'b01, 2'b00, LAT + 1);
        check_state("at_top");

        // Wrap both ways on channel 0.
        press(2'b01, 2'b00, LAT + 1);
        check_state("wrap_up");
        press(2'b00, 2'b01, LAT + 1);
        check_state("wrap_dn");

        // Opposing presses cancel.
        press(2'b01, 2'b01, LAT + 1);
        check_state("cancel");

        // Clear in the very cycle a channel 1 press event lands.
        @(negedge clk);
        inc_n[1] = 1'b0;
        tick(LAT - 1);
        clear = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (mdl[c] != 4'h0) begin
                sb_q.push_back('{ch: c, val: 4'h0, wr: 1'b0, due: cyc + 1});
                mdl[c] = 4'h0;
            end
        end
        @(negedge clk);
        clear = 1'b0;
        tick(4);
        inc_n[1] = 1'b1;
        tick(2 * LAT);
        check_state("clear");

        // Count to 7, then reset in the middle of a debounce.
        while (mdl[0] != 4'h7) press(2'b01, 2'b00, LAT + 1);
        check_state("seven");
        @(negedge clk);
        inc_n[0] = 1'b0;
        tick(3);
        #2 reset_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check_eq("async_rst_cnt", count, 8'h00);
        check_eq("async_rst_wrap", wrap, 2'b00);
        for (int c = 0; c < CH; c++) mdl[c] = '0;
        inc_n[0] = 1'b1;
        inc_n[1] = 1'b0;
        tick(3);
        reset_n = 1'b1;
        push_step(1, 1'b1);
        #1 mon_en = 1'b1;
        tick(10);
        inc_n[1] = 1'b1;
        tick(2 * LAT);
        check_state("post_rst");

        // Saturating instance: dec at zero holds, then an inc still counts.
        sat_wrap_seen = 1'b0;
        sat_min_dropped = 1'b0;
        @(negedge clk);
        s_dec_n[1] = 1'b0;
        tick(10);
        s_dec_n[1] = 1'b1;
        tick(2 * LAT);
        check_eq("sat_cnt_hold", s_count[7:4], 4'h0);
        check_eq("sat_min_kept", sat_min_dropped, 1'b0);
        check_eq("sat_no_wrap", sat_wrap_seen, 1'b0);
        s_inc_n[1] = 1'b0;
        tick(10);
        s_inc_n[1] = 1'b1;
        tick(2 * LAT);
        check_eq("sat_cnt_inc", s_count[7:4], 4'h1);
        check_eq("sat_min_clr", s_at_min[1], 1'b0);
        check_eq("sat_ch0_idle", s_count[3:0], 4'h0);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/updown_counter_bank.md
UPDOWN_COUNTER_BANK -- requirements
Module: updown_counter_bank

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2: number of independent counter channels, range 1..8.
REQ-002 The block SHALL have parameter WIDTH, default 10: bits per channel counter, range 2..32.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 means wrap-around at the limits, 1 means clamp at the limits.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: number of consecutive stable clocks required to accept a key level change, minimum 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port inc_n, input, CHANNELS bits: per-channel increment key, asynchronous, active-low (0 = pressed).
REQ-008 The block SHALL have port dec_n, input, CHANNELS bits: per-channel decrement key, asynchronous, active-low.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous, active-high clear of all channels.
REQ-010 The block SHALL have port count, output, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 The block SHALL have port at_max, output, CHANNELS bits: channel count equals 2^WIDTH-1.
REQ-012 The block SHALL have port at_min, output, CHANNELS bits: channel count equals 0.
REQ-013 The block SHALL have port wrap, output, CHANNELS bits: one-cycle pulse when a channel wraps.

Function
REQ-014 Each inc_n/dec_n bit SHALL pass through a 2-flop synchroniser before any other logic uses it.
REQ-015 Each synchronised key SHALL feed a filter holding an accepted level; the filter SHALL adopt a new level only after the synchronised input differs from the accepted level for DEBOUNCE_CYCLES consecutive clocks.
REQ-016 Any single-cycle return of the input to the accepted level SHALL restart the filter's stability count from zero.
REQ-017 A press event SHALL be a one-cycle pulse in the clock after the accepted level changes 1->0; a release SHALL generate no event.
REQ-018 Holding a key SHALL generate exactly one press event (no auto-repeat).
REQ-019 On an inc press event, the channel SHALL increment by 1 in the next clock; on a dec press event, it SHALL decrement by 1 in the next clock.
REQ-020 Simultaneous inc and dec press events on the same channel SHALL leave that channel's count unchanged and assert no wrap.
REQ-021 clear=1 SHALL set all counts to 0 in the next clock, take priority over press events in that cycle, and assert no wrap.
REQ-022 With SATURATE=0, an increment from 2^WIDTH-1 SHALL give 0 and a decrement from 0 SHALL give 2^WIDTH-1; either case SHALL pulse wrap[i] in the same clock the count updates.
REQ-023 With SATURATE=1, an increment at max or a decrement at 0 SHALL hold the count and SHALL NOT pulse wrap.
REQ-024 at_max and at_min SHALL be decoded combinationally from the registered count.
REQ-025 Channels SHALL be fully independent: events on one channel SHALL NOT affect any other channel.

Reset
REQ-026 reset_n=0 SHALL asynchronously force: count=0, wrap=0, all synchroniser flops and accepted levels to 1 (released), and all stability counters to 0.
REQ-027 After reset, at_min SHALL be all ones and at_max all zeros.
REQ-028 A key held at 0 through reset release SHALL generate one press event after synchronisation plus debounce; this is required behaviour.

Configuration
REQ-029 With macro UPDOWN_COUNTER_DEBOUNCE_EN defined, the filter of REQ-015..016 SHALL be present.
REQ-030 Without UPDOWN_COUNTER_DEBOUNCE_EN, the accepted level SHALL equal the synchronised input registered once, DEBOUNCE_CYCLES SHALL be ignored, and all other requirements SHALL still hold.

Verification
REQ-031 CHANNELS=2, WIDTH=4, SATURATE=0, DEBOUNCE_CYCLES=4: press inc_n[0] for 10 clocks -> count[3:0] goes 0->1 once; channel 1 stays 0.
REQ-032 Same configuration, inc_n[0] glitch pattern 0,0,0,1,0,0,0,0 -> exactly one increment, occurring after the final 4-cycle stable run.
REQ-033 Channel 0 at 15, inc press -> count 0, with wrap[0] high for exactly 1 clock; then dec press -> count 15, with one wrap pulse.
REQ-034 SATURATE=1, channel 1 at 0, dec press -> count stays 0, wrap[1] stays 0, at_min[1] stays 1.
REQ-035 inc and dec pressed in the same clock on channel 0 -> count unchanged; clear asserted in the same clock as a press on channel 1 -> both channels read 0.
REQ-036 reset_n pulsed low mid-debounce with the count at 7 -> count reads 0 immediately (asynchronously), and no event is produced from the interrupted debounce.
